// File: rtl/morse_decoder_fsm.sv
// Morse key decoder: samples a debounced key once per 0.2 s tick, assembles dot/dash
// elements into a letter, emits ITU character codes and a space code after a word gap.
module morse_decoder_fsm #(
   parameter int DASH_MIN   = 3,
   parameter int LETTER_GAP = 4,
   parameter int WORD_GAP   = 10
) (
   input  logic       clk_s02,
   input  logic       rst,
   input  logic       key_in,
   input  logic       clr,
   output logic [4:0] sym_bits,
   output logic [2:0] sym_len,
   output logic [5:0] char_code,
   output logic       char_valid,
   output logic       err,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS     = 2'd1,
      GAP       = 2'd2,
      WORD_WAIT = 2'd3
   } state_t;

   localparam logic [3:0] DASH_MIN_C   = 4'(DASH_MIN);
   localparam logic [7:0] LETTER_GAP_C = 8'(LETTER_GAP);
   localparam logic [7:0] WORD_GAP_C   = 8'(WORD_GAP);
   localparam logic [3:0] PRESS_MAX    = 4'd15;
   localparam logic [2:0] LEN_MAX      = 3'd5;
   localparam logic [5:0] CODE_SPACE   = 6'd36;
   localparam logic [5:0] CODE_INVALID = 6'd63;

   state_t     state_r;
   logic [3:0] press_cnt_r;
   logic [7:0] gap_cnt_r;
   logic       overflow_r;

   logic       element_s;
   logic [7:0] gap_next_s;
   logic [5:0] letter_code_s;

   // The first element of a letter sits at bit (len-1), the newest at bit 0.
   function automatic logic [5:0] lookup(input logic [2:0] len, input logic [4:0] bits);
      logic [5:0] code;
      case ({len, bits})
         {3'd2, 5'b00001}: code = 6'd0;   // A .-
         {3'd4, 5'b01000}: code = 6'd1;   // B -...
         {3'd4, 5'b01010}: code = 6'd2;   // C -.-.
         {3'd3, 5'b00100}: code = 6'd3;   // D -..
         {3'd1, 5'b00000}: code = 6'd4;   // E .
         {3'd4, 5'b00010}: code = 6'd5;   // F ..-.
         {3'd3, 5'b00110}: code = 6'd6;   // G --.
         {3'd4, 5'b00000}: code = 6'd7;   // H ....
         {3'd2, 5'b00000}: code = 6'd8;   // I ..
         {3'd4, 5'b00111}: code = 6'd9;   // J .---
         {3'd3, 5'b00101}: code = 6'd10;  // K -.-
         {3'd4, 5'b00100}: code = 6'd11;  // L .-..
         {3'd2, 5'b00011}: code = 6'd12;  // M --
         {3'd2, 5'b00010}: code = 6'd13;  // N -.
         {3'd3, 5'b00111}: code = 6'd14;  // O ---
         {3'd4, 5'b00110}: code = 6'd15;  // P .--.
         {3'd4, 5'b01101}: code = 6'd16;  // Q --.-
         {3'd3, 5'b00010}: code = 6'd17;  // R .-.
         {3'd3, 5'b00000}: code = 6'd18;  // S ...
         {3'd1, 5'b00001}: code = 6'd19;  // T -
         {3'd3, 5'b00001}: code = 6'd20;  // U ..-
         {3'd4, 5'b00001}: code = 6'd21;  // V ...-
         {3'd3, 5'b00011}: code = 6'd22;  // W .--
         {3'd4, 5'b01001}: code = 6'd23;  // X -..-
         {3'd4, 5'b01011}: code = 6'd24;  // Y -.--
         {3'd4, 5'b01100}: code = 6'd25;  // Z --..
         {3'd5, 5'b11111}: code = 6'd26;  // 0 -----
         {3'd5, 5'b01111}: code = 6'd27;  // 1 .----
         {3'd5, 5'b00111}: code = 6'd28;  // 2 ..---
         {3'd5, 5'b00011}: code = 6'd29;  // 3 ...--
         {3'd5, 5'b00001}: code = 6'd30;  // 4 ....-
         {3'd5, 5'b00000}: code = 6'd31;  // 5 .....
         {3'd5, 5'b10000}: code = 6'd32;  // 6 -....
         {3'd5, 5'b11000}: code = 6'd33;  // 7 --...
         {3'd5, 5'b11100}: code = 6'd34;  // 8 ---..
         {3'd5, 5'b11110}: code = 6'd35;  // 9 ----.
         default:          code = CODE_INVALID;
      endcase
      return code;
   endfunction

   // Element classification, next gap count and the code a letter would decode to.
   always_comb begin
      element_s  = (press_cnt_r >= DASH_MIN_C);
      gap_next_s = gap_cnt_r + 8'd1;
      if (overflow_r) begin
         letter_code_s = CODE_INVALID;
      end else begin
         letter_code_s = lookup(sym_len, sym_bits);
      end
   end

   // Decoder state machine with all outputs registered.
   always_ff @(posedge clk_s02 or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         press_cnt_r <= 4'd0;
         gap_cnt_r   <= 8'd0;
         overflow_r  <= 1'b0;
         sym_bits    <= 5'd0;
         sym_len     <= 3'd0;
         char_code   <= 6'd0;
         char_valid  <= 1'b0;
         err         <= 1'b0;
         busy        <= 1'b0;
      end else if (clr) begin
         // Abandon takes priority over any emission due on this edge.
         state_r     <= IDLE;
         press_cnt_r <= 4'd0;
         gap_cnt_r   <= 8'd0;
         overflow_r  <= 1'b0;
         sym_bits    <= 5'd0;
         sym_len     <= 3'd0;
         char_valid  <= 1'b0;
         err         <= 1'b0;
         busy        <= 1'b0;
      end else begin
         char_valid <= 1'b0;
         err        <= 1'b0;
         case (state_r)
            IDLE: begin
               if (key_in) begin
                  state_r     <= PRESS;
                  press_cnt_r <= 4'd1;
                  busy        <= 1'b1;
               end else begin
                  busy <= 1'b0;
               end
            end
            PRESS: begin
               busy <= 1'b1;
               if (key_in) begin
                  if (press_cnt_r != PRESS_MAX) begin
                     press_cnt_r <= press_cnt_r + 4'd1;
                  end else begin
                     press_cnt_r <= PRESS_MAX;
                  end
               end else begin
                  // A sixth element poisons the letter but keeps the first five visible.
                  if (sym_len == LEN_MAX) begin
                     overflow_r <= 1'b1;
                  end else begin
                     sym_bits <= {sym_bits[3:0], element_s};
                     sym_len  <= sym_len + 3'd1;
                  end
                  state_r     <= GAP;
                  gap_cnt_r   <= 8'd1;
                  press_cnt_r <= 4'd0;
               end
            end
            GAP: begin
               busy <= 1'b1;
               if (key_in) begin
                  state_r     <= PRESS;
                  press_cnt_r <= 4'd1;
                  gap_cnt_r   <= 8'd0;
               end else if (gap_next_s == LETTER_GAP_C) begin
                  char_valid <= 1'b1;
                  char_code  <= letter_code_s;
                  err        <= (letter_code_s == CODE_INVALID);
                  sym_bits   <= 5'd0;
                  sym_len    <= 3'd0;
                  overflow_r <= 1'b0;
                  gap_cnt_r  <= gap_next_s;
                  state_r    <= WORD_WAIT;
               end else begin
                  gap_cnt_r <= gap_next_s;
               end
            end
            WORD_WAIT: begin
               if (key_in) begin
                  state_r     <= PRESS;
                  press_cnt_r <= 4'd1;
                  gap_cnt_r   <= 8'd0;
                  busy        <= 1'b1;
               end else if (gap_next_s == WORD_GAP_C) begin
                  char_valid <= 1'b1;
                  char_code  <= CODE_SPACE;
                  gap_cnt_r  <= 8'd0;
                  state_r    <= IDLE;
                  busy       <= 1'b0;
               end else begin
                  gap_cnt_r <= gap_next_s;
                  busy      <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               press_cnt_r <= 4'd0;
               gap_cnt_r   <= 8'd0;
               overflow_r  <= 1'b0;
               sym_bits    <= 5'd0;
               sym_len     <= 3'd0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_decoder_fsm.sv
// Bench for morse_decoder_fsm: table of letters driven through a scoreboard of expected
// emissions, plus hand sequences for reset, timing, word gap and abandon corners.
`timescale 1ns/1ps
module tb_morse_decoder_fsm;

   logic       clk_s02 = 1'b0;
   logic       rst;
   logic       key_in;
   logic       clr;
   logic [4:0] sym_bits;
   logic [2:0] sym_len;
   logic [5:0] char_code;
   logic       char_valid;
   logic       err;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   logic [5:0] exp_q[$];

   typedef struct {
      string      name;
      int         n;
      logic [5:0] pat;
      int         dot_len;
      int         dash_len;
      logic [5:0] code;
   } vec_t;

   vec_t vecs[16];

   morse_decoder_fsm #(
      .DASH_MIN  (3),
      .LETTER_GAP(4),
      .WORD_GAP  (10)
   ) dut (
      .clk_s02   (clk_s02),
      .rst       (rst),
      .key_in    (key_in),
      .clr       (clr),
      .sym_bits  (sym_bits),
      .sym_len   (sym_len),
      .char_code (char_code),
      .char_valid(char_valid),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk_s02 = ~clk_s02;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic k);
      key_in = k;
      @(posedge clk_s02);
      #1;
   endtask

   task automatic lows(input int n);
      for (int i = 0; i < n; i++) tick(1'b0);
   endtask

   // Scoreboard: every strobe must match the oldest expected emission.
   always @(negedge clk_s02) begin : monitor
      logic [5:0] e;
      if (rst === 1'b0) begin
         if (char_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe: got code %0d expected no strobe", char_code);
            end else begin
               e = exp_q.pop_front();
               chk("sb_code", {26'd0, char_code}, {26'd0, e});
               chk("sb_err", {31'd0, err}, {31'd0, (e == 6'd63)});
            end
         end else begin
            chk("err_without_strobe", {31'd0, err}, 32'd0);
         end
      end
   end

   task automatic send_letter(input vec_t v);
      int hl;
      exp_q.push_back(v.code);
      for (int i = v.n - 1; i >= 0; i--) begin
         hl = v.pat[i] ? v.dash_len : v.dot_len;
         for (int j = 0; j < hl; j++) tick(1'b1);
         if (i > 0) tick(1'b0);
      end
      lows(4);
      chk({v.name, "_valid"}, {31'd0, char_valid}, 32'd1);
      chk({v.name, "_code"}, {26'd0, char_code}, {26'd0, v.code});
      chk({v.name, "_len_after"}, {29'd0, sym_len}, 32'd0);
      chk({v.name, "_bits_after"}, {27'd0, sym_bits}, 32'd0);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_bits"}, {27'd0, sym_bits}, 32'd0);
      chk({name, "_len"}, {29'd0, sym_len}, 32'd0);
      chk({name, "_code"}, {26'd0, char_code}, 32'd0);
      chk({name, "_valid"}, {31'd0, char_valid}, 32'd0);
      chk({name, "_err"}, {31'd0, err}, 32'd0);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{"E",        1, 6'b000000, 1, 3,  6'd4};
      vecs[1]  = '{"E_2tick",  1, 6'b000000, 2, 3,  6'd4};
      vecs[2]  = '{"T",        1, 6'b000001, 1, 3,  6'd19};
      vecs[3]  = '{"T_4tick",  1, 6'b000001, 1, 4,  6'd19};
      vecs[4]  = '{"A",        2, 6'b000001, 1, 3,  6'd0};
      vecs[5]  = '{"N",        2, 6'b000010, 1, 3,  6'd13};
      vecs[6]  = '{"S",        3, 6'b000000, 1, 3,  6'd18};
      vecs[7]  = '{"O",        3, 6'b000111, 1, 3,  6'd14};
      vecs[8]  = '{"Q",        4, 6'b001101, 1, 3,  6'd16};
      vecs[9]  = '{"H",        4, 6'b000000, 1, 3,  6'd7};
      vecs[10] = '{"Z",        4, 6'b001100, 1, 3,  6'd25};
      vecs[11] = '{"D0_hold",  5, 6'b011111, 1, 20, 6'd26};
      vecs[12] = '{"D1",       5, 6'b001111, 1, 3,  6'd27};
      vecs[13] = '{"D5",       5, 6'b000000, 1, 3,  6'd31};
      vecs[14] = '{"bad_4",    4, 6'b000011, 1, 3,  6'd63};
      vecs[15] = '{"six_dots", 6, 6'b000000, 1, 3,  6'd63};

      rst    = 1'b1;
      key_in = 1'b0;
      clr    = 1'b0;
      repeat (2) @(posedge clk_s02);
      #1;
      check_all_zero("reset_held");
      rst = 1'b0;

      // Asynchronous reset in the middle of a press.
      tick(1'b1);
      tick(1'b1);
      chk("busy_in_press", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1 check_all_zero("reset_mid_press");
      @(posedge clk_s02);
      #1 rst = 1'b0;
      lows(12);
      chk("busy_after_reset", {31'd0, busy}, 32'd0);

      // 'E' with exact strobe timing, then the word gap space.
      exp_q.push_back(6'd4);
      tick(1'b1);
      tick(1'b0);
      chk("e_len", {29'd0, sym_len}, 32'd1);
      chk("e_bits", {27'd0, sym_bits}, 32'd0);
      chk("e_busy", {31'd0, busy}, 32'd1);
      lows(2);
      chk("e_no_strobe_3rd_low", {31'd0, char_valid}, 32'd0);
      tick(1'b0);
      chk("e_strobe_4th_low", {31'd0, char_valid}, 32'd1);
      chk("e_code", {26'd0, char_code}, 32'd4);
      tick(1'b0);
      chk("e_strobe_one_cycle", {31'd0, char_valid}, 32'd0);
      chk("e_code_held", {26'd0, char_code}, 32'd4);
      lows(4);
      chk("no_space_9th_low", {31'd0, char_valid}, 32'd0);
      chk("busy_word_wait", {31'd0, busy}, 32'd1);
      exp_q.push_back(6'd36);
      tick(1'b0);
      chk("space_strobe", {31'd0, char_valid}, 32'd1);
      chk("space_code", {26'd0, char_code}, 32'd36);
      chk("space_busy", {31'd0, busy}, 32'd0);

      // 'A' with the in-progress pattern visible before emission.
      exp_q.push_back(6'd0);
      tick(1'b1);
      tick(1'b0);
      repeat (3) tick(1'b1);
      tick(1'b0);
      chk("a_bits", {27'd0, sym_bits}, 32'd1);
      chk("a_len", {29'd0, sym_len}, 32'd2);
      lows(3);
      chk("a_strobe", {31'd0, char_valid}, 32'd1);
      chk("a_code", {26'd0, char_code}, 32'd0);

      for (int i = 0; i < 16; i++) send_letter(vecs[i]);
      exp_q.push_back(6'd36);
      lows(6);
      chk("table_space", {31'd0, char_valid}, 32'd1);

      // Abandon on the edge that would complete a letter.
      tick(1'b1);
      lows(3);
      clr = 1'b1;
      tick(1'b0);
      clr = 1'b0;
      chk("clr_letter_valid", {31'd0, char_valid}, 32'd0);
      chk("clr_letter_len", {29'd0, sym_len}, 32'd0);
      chk("clr_letter_busy", {31'd0, busy}, 32'd0);
      lows(12);

      // Abandon on the edge that would emit the space.
      exp_q.push_back(6'd4);
      tick(1'b1);
      lows(9);
      clr = 1'b1;
      tick(1'b0);
      clr = 1'b0;
      chk("clr_space_valid", {31'd0, char_valid}, 32'd0);
      chk("clr_space_busy", {31'd0, busy}, 32'd0);
      lows(6);

      // Reset mid-letter discards it and clears the held code.
      tick(1'b1);
      tick(1'b0);
      chk("pre_reset_len", {29'd0, sym_len}, 32'd1);
      #2 rst = 1'b1;
      #1 check_all_zero("reset_mid_letter");
      @(posedge clk_s02);
      #1 rst = 1'b0;
      lows(12);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/morse_decoder_fsm.md
MORSE_DECODER_FSM -- requirements
Module: morse_decoder_fsm

Interface
REQ-001 SHALL have parameter DASH_MIN, default 3: minimum consecutive high samples classified as dash.
REQ-002 SHALL have parameter LETTER_GAP, default 4: consecutive low samples that terminate a letter.
REQ-003 SHALL have parameter WORD_GAP, default 10: consecutive low samples, counted from release, that terminate a word.
REQ-004 clk_s02  input  1  sampling clock, one 0.2 s tick; all state changes on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 key_in  input  1  debounced Morse key level, 1 = pressed; sampled once per posedge.
REQ-007 clr  input  1  synchronous abandon: discard current letter without emission.
REQ-008 sym_bits  output  5  elements of the letter in progress, 1 = dash; newest element in bit 0.
REQ-009 sym_len  output  3  element count of the letter in progress, 0..5.
REQ-010 char_code  output  6  decoded character: A..Z = 0..25, '0'..'9' = 26..35, space = 36, invalid = 63.
REQ-011 char_valid  output  1  one-cycle strobe qualifying char_code.
REQ-012 err  output  1  asserted with char_valid when the emitted code is 63.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement four states: IDLE, PRESS, GAP, WORD_WAIT.
REQ-015 IDLE: key_in=1 -> PRESS with press_cnt=1; key_in=0 -> remain; no emission from IDLE.
REQ-016 PRESS, key_in=1: press_cnt increments and saturates at 15; a held key remains a dash.
REQ-017 PRESS, key_in=0: classify dash if press_cnt>=DASH_MIN, else dot; sym_bits <= {sym_bits[3:0], element}; sym_len increments; -> GAP with gap_cnt=1.
REQ-018 A 6th element SHALL set an internal overflow flag; sym_len holds at 5; sym_bits is not shifted.
REQ-019 GAP, key_in=1: -> PRESS with press_cnt=1, gap_cnt cleared.
REQ-020 GAP, key_in=0: gap_cnt increments; on the edge where gap_cnt reaches LETTER_GAP: char_valid<=1, char_code<=lookup(sym_len, sym_bits), sym_bits/sym_len cleared, -> WORD_WAIT.
REQ-021 Lookup SHALL cover the standard ITU patterns for A..Z and 0..9; any other pattern, or overflow set, yields 63 with err=1; overflow clears on emission.
REQ-022 WORD_WAIT, key_in=0: gap_cnt continues; at gap_cnt==WORD_GAP emit char_code=36, char_valid=1 once, -> IDLE.
REQ-023 WORD_WAIT, key_in=1: -> PRESS with press_cnt=1; no space emitted.
REQ-024 char_valid and err SHALL be high for exactly one clk_s02 period; char_code holds its last value until the next emission.
REQ-025 clr=1 on any edge: clear sym_bits, sym_len, overflow, counters; -> IDLE; no emission, including on an edge that would have completed a letter or space (clr wins).
REQ-026 Outputs SHALL be registered; sym_bits/sym_len reflect an element on the edge after its release sample.

Reset
REQ-027 rst SHALL force IDLE, sym_bits=0, sym_len=0, char_code=0, char_valid=0, err=0, busy=0, all counters and overflow 0, immediately and regardless of clock.
REQ-028 rst asserted mid-letter SHALL discard the letter; no emission after release.

Verification
REQ-029 Reset: assert rst mid-PRESS -> all outputs 0 same cycle, busy=0.
REQ-030 'E': key 1 tick high, then low -> char_valid on 4th low edge, char_code=4, err=0.
REQ-031 'A': 1 high, 1 low, 3 high, 4 low -> char_code=0; sym_bits=5'b00001, sym_len=2 before emission.
REQ-032 '0': five dashes (3 high/1 low each), then 4 low -> char_code=26; 20-tick hold on one dash still counts as dash.
REQ-033 Six dots then 4 low -> char_code=63, err=1 for one cycle, sym_len=0 afterward.
REQ-034 'E' then key low for 10 ticks total -> codes 4 then 36, two separate strobes; clr on the 4th low edge of a letter -> no strobe.
